// File: rtl/sdf_twiddle_mult.sv
// Twiddle multiplier for one radix-2 DIF SDF stage: tracks block position, addresses the ROM and rotates second-half samples.
// Latency 3 cycles, first-half bypass matched; no backpressure, one sample per cycle sustained.
module sdf_twiddle_mult #(
    parameter int NFFT       = 128,
    parameter int DATA_WIDTH = 16,
    parameter int STAGE      = 0,
    parameter int FRAC_BITS  = 14
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sync_clr,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH-1:0]           in_real,
    input  logic [DATA_WIDTH-1:0]           in_imag,
    output logic [$clog2(NFFT/2)-1:0]       tw_addr,
    input  logic [DATA_WIDTH-1:0]           tw_real,
    input  logic [DATA_WIDTH-1:0]           tw_imag,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_real,
    output logic [DATA_WIDTH-1:0]           out_imag,
    output logic                            out_last
);

    localparam int NS = NFFT >> STAGE;
    localparam int CW = $clog2(NS);
    localparam int AW = $clog2(NFFT / 2);
    localparam int PW = 2 * DATA_WIDTH;

    localparam logic [CW-1:0] HALF = CW'(NS / 2);
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    localparam logic signed [PW:0] RND  = {{PW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [PW:0] SMAX = {{(DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] SMIN = {{(DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] OMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] OMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [CW-1:0] r_cnt;
    logic          w_second;
    logic [CW-1:0] w_k;
    logic [AW-1:0] w_k_ext;

    logic                         r1_vld, r1_byp, r1_last;
    logic signed [DATA_WIDTH-1:0] r1_ar, r1_ai, r1_wr, r1_wi;

    logic                         r2_vld, r2_byp, r2_last;
    logic signed [DATA_WIDTH-1:0] r2_ar, r2_ai;
    logic signed [PW-1:0]         r2_rr, r2_ii, r2_ri, r2_ir;

    logic signed [PW:0]           w_re_full, w_im_full, w_re_sh, w_im_sh;

    logic                         r_out_valid, r_out_last;
    logic [DATA_WIDTH-1:0]        r_out_real, r_out_imag;

    // sync_clr wins over increment; the sample in that cycle still sees the old position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (sync_clr) begin
            r_cnt <= '0;
        end else if (in_valid) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign w_second = (r_cnt >= HALF);
    assign w_k      = r_cnt - HALF;
    assign w_k_ext  = AW'(w_k);
    assign tw_addr  = w_second ? (w_k_ext << STAGE) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_vld  <= 1'b0;
            r1_byp  <= 1'b0;
            r1_last <= 1'b0;
            r1_ar   <= '0;
            r1_ai   <= '0;
            r1_wr   <= '0;
            r1_wi   <= '0;
        end else begin
            r1_vld <= in_valid;
            if (in_valid) begin
                r1_ar   <= $signed(in_real);
                r1_ai   <= $signed(in_imag);
                r1_wr   <= $signed(tw_real);
                r1_wi   <= $signed(tw_imag);
                r1_byp  <= ~w_second;
                r1_last <= (r_cnt == LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_vld  <= 1'b0;
            r2_byp  <= 1'b0;
            r2_last <= 1'b0;
            r2_ar   <= '0;
            r2_ai   <= '0;
            r2_rr   <= '0;
            r2_ii   <= '0;
            r2_ri   <= '0;
            r2_ir   <= '0;
        end else begin
            r2_vld <= r1_vld;
            if (r1_vld) begin
                r2_byp  <= r1_byp;
                r2_last <= r1_last;
                r2_ar   <= r1_ar;
                r2_ai   <= r1_ai;
                r2_rr   <= r1_ar * r1_wr;
                r2_ii   <= r1_ai * r1_wi;
                r2_ri   <= r1_ar * r1_wi;
                r2_ir   <= r1_ai * r1_wr;
            end
        end
    end

    // one guard bit keeps the sum of two full-scale products exact before rounding
    assign w_re_full = r2_rr - r2_ii + RND;
    assign w_im_full = r2_ri + r2_ir + RND;
    assign w_re_sh   = w_re_full >>> FRAC_BITS;
    assign w_im_sh   = w_im_full >>> FRAC_BITS;

    function automatic logic [DATA_WIDTH-1:0] sat(input logic signed [PW:0] v);
        if (v > SMAX) begin
            return OMAX;
        end else if (v < SMIN) begin
            return OMIN;
        end
        return v[DATA_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_real  <= '0;
            r_out_imag  <= '0;
        end else begin
            r_out_valid <= r2_vld;
            if (r2_vld) begin
                r_out_last <= r2_last;
                r_out_real <= r2_byp ? r2_ar : sat(w_re_sh);
                r_out_imag <= r2_byp ? r2_ai : sat(w_im_sh);
            end
        end
    end

    // last flag is held across bubbles but only shown alongside a valid output
    assign out_valid = r_out_valid;
    assign out_real  = r_out_real;
    assign out_imag  = r_out_imag;
    assign out_last  = r_out_last & r_out_valid;

endmodule

// File: tb/tb_sdf_twiddle_mult.sv
// Directed bench for sdf_twiddle_mult: a STAGE=0 instance fully checked, a STAGE=2 instance for addressing.
module tb_sdf_twiddle_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_real = '0;
    logic [15:0] in_imag = '0;

    logic [5:0]  a0, a2;
    logic [15:0] tw_re0, tw_im0, tw_re2, tw_im2;
    logic        o_vld, o_last, o2_vld, o2_last;
    logic [15:0] o_re, o_im, o2_re, o2_im;

    logic        ovr = 1'b0;
    logic [15:0] ovr_re = '0;
    logic [15:0] ovr_im = '0;
    logic [15:0] rom_re [64];
    logic [15:0] rom_im [64];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hold_err = 0;
    int last_err = 0;
    bit prev_ok = 0;
    logic [15:0] prev_re, prev_im;

    int in_cyc_q[$], a0_q[$], a2_q[$];
    int ob_re[$], ob_im[$], ob_last[$], ob_cyc[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign tw_re0 = ovr ? ovr_re : rom_re[a0];
    assign tw_im0 = ovr ? ovr_im : rom_im[a0];
    assign tw_re2 = ovr ? ovr_re : rom_re[a2];
    assign tw_im2 = ovr ? ovr_im : rom_im[a2];

    sdf_twiddle_mult #(.NFFT(128), .DATA_WIDTH(16), .STAGE(0), .FRAC_BITS(14)) dut0 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag), .tw_addr(a0), .tw_real(tw_re0), .tw_imag(tw_im0),
        .out_valid(o_vld), .out_real(o_re), .out_imag(o_im), .out_last(o_last));

    sdf_twiddle_mult #(.NFFT(128), .DATA_WIDTH(16), .STAGE(2), .FRAC_BITS(14)) dut2 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag), .tw_addr(a2), .tw_real(tw_re2), .tw_imag(tw_im2),
        .out_valid(o2_vld), .out_real(o2_re), .out_imag(o2_im), .out_last(o2_last));

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (in_valid && rst_n) begin
            in_cyc_q.push_back(cyc);
            a0_q.push_back(int'(a0));
            a2_q.push_back(int'(a2));
        end
        if (o_vld) begin
            ob_re.push_back(int'($signed(o_re)));
            ob_im.push_back(int'($signed(o_im)));
            ob_last.push_back(int'(o_last));
            ob_cyc.push_back(cyc);
        end
        if (o_last && !o_vld) last_err++;
        if (!rst_n) begin
            prev_ok = 0;
        end else begin
            if (prev_ok && !o_vld && (o_re !== prev_re || o_im !== prev_im)) hold_err++;
            prev_re = o_re;
            prev_im = o_im;
            prev_ok = 1;
        end
    end

    function automatic int rnd(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Reference result for a sample at block position pos of a STAGE=0 block.
    function automatic logic [31:0] golden(int pos, int ar, int ai);
        longint re, im;
        int wr, wi, k;
        if (pos < 64) return {ar[15:0], ai[15:0]};
        k  = pos - 64;
        wr = int'($signed(rom_re[k]));
        wi = int'($signed(rom_im[k]));
        re = (longint'(ar) * wr - longint'(ai) * wi + 8192) >>> 14;
        im = (longint'(ar) * wi + longint'(ai) * wr + 8192) >>> 14;
        if (re > 32767) re = 32767;
        if (re < -32768) re = -32768;
        if (im > 32767) im = 32767;
        if (im < -32768) im = -32768;
        return {re[15:0], im[15:0]};
    endfunction

    task automatic chk(input string tag, input int idx, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic send(input bit clr, input int re, input int im);
        in_valid = 1'b1;
        sync_clr = clr;
        in_real  = re[15:0];
        in_imag  = im[15:0];
        tick();
        in_valid = 1'b0;
        sync_clr = 1'b0;
    endtask

    task automatic send_g(input bit clr, input int pos, input int re, input int im);
        exp_q.push_back(golden(pos, re, im));
        send(clr, re, im);
    endtask

    task automatic clear_q();
        in_cyc_q.delete(); a0_q.delete(); a2_q.delete();
        ob_re.delete(); ob_im.delete(); ob_last.delete(); ob_cyc.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        sync_clr = 1'b0;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        tick();
        clear_q();
    endtask

    task automatic chk_stream(input string tag, input int n);
        chk({tag, "_count"}, 0, ob_re.size(), n);
        if (ob_re.size() == n && exp_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_re"}, i, ob_re[i], int'($signed(exp_q[i][31:16])));
                chk({tag, "_im"}, i, ob_im[i], int'($signed(exp_q[i][15:0])));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            int c, s;
            c = rnd(16384.0 * $cos(2.0 * 3.14159265358979 * k / 128.0));
            s = rnd(-16384.0 * $sin(2.0 * 3.14159265358979 * k / 128.0));
            rom_re[k] = c[15:0];
            rom_im[k] = s[15:0];
        end

        // reset state
        #2;
        chk("rst_out_valid", 0, o_vld, 0);
        chk("rst_out_real", 0, o_re, 0);
        chk("rst_out_imag", 0, o_im, 0);
        chk("rst_out_last", 0, o_last, 0);
        chk("rst_tw_addr0", 0, a0, 0);
        chk("rst_tw_addr2", 0, a2, 0);
        idle(2);
        rst_n = 1'b1;
        tick();
        clear_q();

        // one full block of (1000,0)
        for (int i = 0; i < 128; i++) send_g(0, i, 1000, 0);
        idle(6);
        chk_stream("blk", 128);
        if (ob_re.size() == 128 && a0_q.size() == 128 && a2_q.size() == 128) begin
            chk("blk_latency", 0, ob_cyc[0] - in_cyc_q[0], 3);
            for (int i = 0; i < 64; i++) begin
                chk("blk_first_re", i, ob_re[i], 1000);
                chk("blk_first_im", i, ob_im[i], 0);
            end
            chk("blk_o64_re", 64, ob_re[64], 1000);
            chk("blk_o64_im", 64, ob_im[64], 0);
            chk("blk_o96_re", 96, ob_re[96], 0);
            chk("blk_o96_im", 96, ob_im[96], -1000);
            for (int i = 0; i < 128; i++) begin
                chk("blk_last", i, ob_last[i], (i == 127) ? 1 : 0);
                chk("blk_addr0", i, a0_q[i], (i < 64) ? 0 : i - 64);
                chk("s2_addr", i, a2_q[i], ((i % 32) < 16) ? 0 : ((i % 32) - 16) * 4);
            end
        end

        // rounding and saturation with a forced twiddle
        do_reset();
        for (int i = 0; i < 64; i++) send(0, 0, 0);
        ovr = 1'b1; ovr_re = 16'd8192; ovr_im = 16'd0;
        send(0, 3, 0);
        send(0, -3, 0);
        ovr_re = 16'd0; ovr_im = 16'hC000;
        send(0, -32768, -32768);
        ovr = 1'b0;
        idle(6);
        chk("rnd_count", 0, ob_re.size(), 67);
        if (ob_re.size() == 67) begin
            chk("rnd_up_re", 64, ob_re[64], 2);
            chk("rnd_up_im", 64, ob_im[64], 0);
            chk("rnd_neg_re", 65, ob_re[65], -1);
            chk("rnd_neg_im", 65, ob_im[65], 0);
            chk("sat_re", 66, ob_re[66], -32768);
            chk("sat_im", 66, ob_im[66], 32767);
        end

        // random bubbles across a block
        do_reset();
        for (int i = 0; i < 128; i++) begin
            idle($urandom_range(0, 2));
            send_g(0, i, i * 200 - 12000, 9000 - i * 150);
        end
        idle(6);
        chk_stream("stall", 128);
        if (ob_re.size() == 128 && in_cyc_q.size() == 128) begin
            for (int i = 0; i < 128; i++) begin
                chk("stall_latency", i, ob_cyc[i] - in_cyc_q[i], 3);
                chk("stall_addr0", i, a0_q[i], (i < 64) ? 0 : i - 64);
                chk("stall_last", i, ob_last[i], (i == 127) ? 1 : 0);
            end
        end

        // sync_clr at position 40, then again at position 65
        do_reset();
        for (int i = 0; i < 40; i++) send_g(0, i, 300 + i, -200);
        send_g(1, 40, 777, 111);
        for (int i = 0; i < 65; i++) send_g(0, i, 1500 - i * 7, 250 + i);
        send_g(1, 65, 2000, -900);
        send_g(0, 0, -321, 654);
        idle(6);
        chk_stream("sync", 108);
        if (a0_q.size() == 108) begin
            chk("sync_addr_at40", 40, a0_q[40], 0);
            chk("sync_addr_next", 41, a0_q[41], 0);
            chk("sync_addr_pos64", 105, a0_q[105], 0);
            chk("sync_addr_old", 106, a0_q[106], 1);
            chk("sync_addr_after", 107, a0_q[107], 0);
        end

        // reset with three samples still inside the pipeline
        do_reset();
        for (int i = 0; i < 73; i++) send(0, 500 + i, 7);
        chk("mrst_pre_count", 0, ob_re.size(), 70);
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 0, o_vld, 0);
        chk("mrst_out_real", 0, o_re, 0);
        chk("mrst_out_imag", 0, o_im, 0);
        tick();
        rst_n = 1'b1;
        idle(6);
        chk("mrst_no_emerge", 0, ob_re.size(), 70);
        send(0, 1234, -55);
        idle(6);
        chk("mrst_post_count", 0, ob_re.size(), 71);
        if (ob_re.size() == 71 && a0_q.size() == 74) begin
            chk("mrst_next_re", 70, ob_re[70], 1234);
            chk("mrst_next_im", 70, ob_im[70], -55);
            chk("mrst_next_addr", 73, a0_q[73], 0);
        end

        chk("hold_on_bubble", 0, hold_err, 0);
        chk("last_without_valid", 0, last_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
